// File: rtl/s2_arb_pkg.sv
// Shared types and constants for the round-robin S2 cell arbiter.
package s2_arb_pkg;

  localparam int FN_W   = 8;
  localparam int FN_D00 = 7;
  localparam int FN_D01 = 6;
  localparam int FN_D10 = 5;
  localparam int FN_D11 = 4;
  localparam int FN_A1  = 3;
  localparam int FN_B1  = 2;
  localparam int FN_A0  = 1;
  localparam int FN_B0  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_vld,
  output logic [IDW-1:0] o_idx
);

  always_comb begin
    logic [IDW-1:0] w_cand;
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % N);
      if (!o_vld && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/s2.sv
// S2 logic cell: 4:1 mux selected by {a1|b1, a0&b0}, registered with synchronous clear.
module s2 (
  input  logic clk,
  input  logic i_d00,
  input  logic i_d01,
  input  logic i_d10,
  input  logic i_d11,
  input  logic i_a1,
  input  logic i_b1,
  input  logic i_a0,
  input  logic i_b0,
  input  logic i_clr,
  output logic o_q
);

  logic [1:0] w_sel;
  logic       w_f;
  logic       r_q;

  assign w_sel = {i_a1 | i_b1, i_a0 & i_b0};

  always_comb begin
    case (w_sel)
      2'd0:    w_f = i_d00;
      2'd1:    w_f = i_d01;
      2'd2:    w_f = i_d10;
      default: w_f = i_d11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_clr) r_q <= 1'b0;
    else       r_q <= w_f;
  end

  assign o_q = r_q;

endmodule

// File: rtl/s2_rr_arbiter.sv
// Round-robin sequencer sharing one S2 cell between N requesters; one response per 2 cycles.
module s2_rr_arbiter
  import s2_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [N-1:0]      req,
  input  logic [N*FN_W-1:0] fn,
  output logic [N-1:0]      ack,
  output logic              rsp_valid,
  output logic              rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  state_e          r_state, w_state_nxt;
  logic [FN_W-1:0] r_fn;
  logic [IDW-1:0]  r_win;
  logic [IDW-1:0]  r_ptr;

  logic [N-1:0]    w_win_oh;
  logic [N-1:0]    w_pick_req;
  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_idx;
  logic            w_sel_en;
  logic [FN_W-1:0] w_fn_sel;
  logic            w_done;
  logic            w_cell_clr;
  logic            w_cell_q;

  assign w_win_oh = N'(1) << r_win;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req (w_pick_req),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  // The just-served requester is masked in DONE so a held req waits one turn.
  always_comb begin
    w_state_nxt = r_state;
    w_pick_req  = '0;
    w_sel_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_pick_req = req;
        if (w_pick_vld) begin
          w_sel_en    = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: w_state_nxt = DONE;
      DONE: begin
        w_pick_req = req & ~w_win_oh;
        if (w_pick_vld) begin
          w_sel_en    = 1'b1;
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_fn_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == w_pick_idx) w_fn_sel = fn[i*FN_W +: FN_W];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_ptr   <= IDW'(N - 1);
      r_fn    <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_en) begin
        r_fn  <= w_fn_sel;
        r_win <= w_pick_idx;
        r_ptr <= w_pick_idx;
      end
    end
  end

  assign w_cell_clr = (r_state != GRANT);

  s2 u_cell (
    .clk   (clk),
    .i_d00 (r_fn[FN_D00]),
    .i_d01 (r_fn[FN_D01]),
    .i_d10 (r_fn[FN_D10]),
    .i_d11 (r_fn[FN_D11]),
    .i_a1  (r_fn[FN_A1]),
    .i_b1  (r_fn[FN_B1]),
    .i_a0  (r_fn[FN_A0]),
    .i_b0  (r_fn[FN_B0]),
    .i_clr (w_cell_clr),
    .o_q   (w_cell_q)
  );

  // Outputs decode from state so an asynchronous reset zeroes them at once.
  assign w_done    = (r_state == DONE);
  assign ack       = w_done ? w_win_oh : '0;
  assign rsp_valid = w_done;
  assign rsp_data  = w_done & w_cell_q;
  assign rsp_id    = w_done ? r_win : '0;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_s2_rr_arbiter.sv
// Directed and randomized bench for s2_rr_arbiter against a transaction-level round-robin model.
module tb_s2_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           clr_n;
  logic [N-1:0]   req;
  logic [N*8-1:0] fn;
  logic [N-1:0]   ack;
  logic           rsp_valid;
  logic           rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr;

  always #5 clk = ~clk;

  s2_rr_arbiter #(.N(N), .IDW(IDW)) u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .fn        (fn),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Cell result from the word: d-bits at 7..4 indexed by sel = 2*(a1|b1) + (a0&b0).
  function automatic logic cell_model(input logic [7:0] w);
    int sel;
    logic [2:0] bi;
    sel = ((w[3] | w[2]) ? 2 : 0) + ((w[1] & w[0]) ? 1 : 0);
    bi  = 3'(7 - sel);
    return w[bi];
  endfunction

  function automatic logic [IDW-1:0] next_winner(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (((m >> c) & 4'b0001) != 4'b0000) return IDW'(c);
    end
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_ack"},   32'(ack),       32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    req   = '0;
    fn    = '0;
    step();
    step();
    chk_quiet_outputs("rst");
    chk("rst_cellq", 32'(u_dut.w_cell_q), 32'd0);
    #2 clr_n = 1'b1;
    m_ptr = N - 1;
  endtask

  // Raise a set of requests together; each requester drops req on its own ack.
  task automatic run_round(input logic [N-1:0] mask, input logic [N*8-1:0] fns, input bit scramble);
    logic [N-1:0]   pend;
    logic [IDW-1:0] w;
    logic [7:0]     wfn;
    fn   = fns;
    req  = mask;
    pend = mask;
    if (mask == '0) begin
      repeat (2) begin
        step();
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy",  32'(busy),      32'd0);
      end
      return;
    end
    while (pend != '0) begin
      w   = next_winner(pend, m_ptr);
      wfn = fns[{w, 3'b000} +: 8];
      step();
      chk("grant_valid", 32'(rsp_valid),      32'd0);
      chk("grant_busy",  32'(busy),           32'd1);
      chk("grant_cellq", 32'(u_dut.w_cell_q), 32'd0);
      if (scramble) fn[{w, 3'b000} +: 8] = ~wfn;
      step();
      chk("done_valid", 32'(rsp_valid),      32'd1);
      chk("done_id",    32'(rsp_id),         32'(w));
      chk("done_data",  32'(rsp_data),       32'(cell_model(wfn)));
      chk("done_ack",   32'(ack),            32'(4'b0001 << w));
      chk("done_cellq", 32'(u_dut.w_cell_q), 32'(cell_model(wfn)));
      req[w]  = 1'b0;
      pend[w] = 1'b0;
      m_ptr   = int'(w);
    end
    step();
    chk("after_busy",  32'(busy),           32'd0);
    chk("after_valid", 32'(rsp_valid),      32'd0);
    chk("after_cellq", 32'(u_dut.w_cell_q), 32'd0);
  endtask

  initial begin
    logic [IDW-1:0] w;
    clr_n = 1'b0;
    req   = '0;
    fn    = '0;
    do_reset();

    // single requests, d01 / d10 selection, fn changed after selection
    run_round(4'b0001, 32'h0000_0043, 1'b0);
    run_round(4'b1000, 32'h2900_0000, 1'b0);
    run_round(4'b1000, 32'hD900_0000, 1'b1);

    // all four at once from reset: order 0,1,2,3
    do_reset();
    run_round(4'b1111, 32'h29D9_FF43, 1'b1);

    // fairness: req0 and req2 both held continuously
    do_reset();
    fn  = 32'h00D9_0043;
    req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      w = next_winner(4'b0101, m_ptr);
      step();
      chk("fair_grant_valid", 32'(rsp_valid), 32'd0);
      step();
      chk("fair_valid", 32'(rsp_valid), 32'd1);
      chk("fair_id",    32'(rsp_id),    32'(w));
      chk("fair_data",  32'(rsp_data),  32'(cell_model(fn[{w, 3'b000} +: 8])));
      if (i == 7) req = '0;
      m_ptr = int'(w);
    end
    step();
    chk("fair_idle_busy", 32'(busy), 32'd0);

    // reset pulse during GRANT of requester 1
    do_reset();
    fn  = 32'h0000_2900;
    req = 4'b0010;
    step();
    chk("mid_grant_busy", 32'(busy), 32'd1);
    #2 clr_n = 1'b0;
    #1 chk_quiet_outputs("mid_async");
    step();
    chk_quiet_outputs("mid_held");
    chk("mid_cellq", 32'(u_dut.w_cell_q), 32'd0);
    #3 clr_n = 1'b1;
    m_ptr = N - 1;
    run_round(4'b0010, 32'h0000_2900, 1'b0);

    // cell output masking with an all-ones word
    chk("mask_idle_cellq", 32'(u_dut.w_cell_q), 32'd0);
    run_round(4'b0010, 32'h0000_FF00, 1'b0);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      run_round(4'($urandom_range(0, 15)), 32'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/s2_rr_arbiter.md
# s2_rr_arbiter

Round-robin arbiter and sequencer that shares one S2 logic cell (4:1 mux, OR/AND select, clocked output flop with synchronous clear) between N requesters. Each requester presents an 8-bit function word. The arbiter grants one requester and latches its word. It drives the shared cell for one capture cycle, then returns the registered cell output with the requester's index. It sits between the requester-side logic blocks and the single `s2` instance it owns.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(N)`: requester index width.
- `clk`  in  1  rising-edge clock.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request level; held high until the matching `ack` bit.
- `fn`  in  N*8  function words, requester i at bits [8i+7:8i]; bit order {d00,d01,d10,d11,a1,b1,a0,b0}.
- `ack`  out  N  one-cycle pulse to the served requester; reset 0.
- `rsp_valid`  out  1  one-cycle pulse, coincident with `ack`; reset 0.
- `rsp_data`  out  1  cell output, valid only while `rsp_valid`; reset 0.
- `rsp_id`  out  IDW  index of the served requester, valid while `rsp_valid`; reset 0.
- `busy`  out  1  high in GRANT and DONE; reset 0.

## Operation
- FSM states are IDLE, GRANT and DONE. Reset state is IDLE.
- In IDLE:
  - If any `req` is high, pick a winner, latch its `fn` into `fn_q`, latch its index into `win_q`, and go to GRANT.
  - Otherwise stay in IDLE.
- In GRANT:
  - Drive the cell inputs from `fn_q` with cell `clr`=0.
  - The cell captures f = mux({a1|b1, a0&b0}) at the end of this cycle.
  - Always go to DONE.
- In DONE:
  - Assert `ack[win_q]`, `rsp_valid`=1, `rsp_data`=cell q and `rsp_id`=`win_q`.
  - Arbitrate `req & ~onehot(win_q)`. On a hit, latch the new winner and go to GRANT; otherwise go to IDLE.
- Cell `clr`=1 in every state except GRANT. The cell output is therefore 0 except in DONE.
- Round-robin picker:
  - Pointer `ptr_q` holds the last served index; its reset value is N-1.
  - Search order is ptr_q+1, ptr_q+2, … modulo N. The first requester with `req` set wins.
  - `ptr_q` updates to the winner at each selection.
- `fn` is sampled only at selection. Changes to `fn` after selection do not affect the result.
- If `req` drops after selection, the operation still completes and `ack` still pulses. This is harmless to the requester.
- A requester whose `req` is still high in the cycle after its `ack` is treated as a new request.

## Timing
- Latency: `req` sampled in IDLE at cycle t → GRANT at t+1 → `rsp_valid` and `ack` at t+2.
- Back-to-back throughput is one response per 2 cycles (DONE→GRANT→DONE).
- The arbiter never grants while in GRANT. New requests wait for IDLE or DONE.
- Simultaneous requests are resolved by pointer order in a single cycle.
- When `clr_n` asserts, the following happen immediately (asynchronous):
  - state goes to IDLE and `ptr_q` to N-1;
  - `fn_q`, `win_q` and every output go to 0.
  - An in-flight operation is discarded without `ack`, and the requester keeps `req` high to be re-served.
- Cell clear on reset: the cell flop clears synchronously, not asynchronously. While `clr_n` is low, cell `clr` is driven 1 (state is IDLE), so the cell output reads 0 from the first clock edge after reset.
- Reset release: first arbitration happens on the first rising edge with `clr_n`=1.

## Structure
- Package `s2_arb_pkg` holds:
  - the state enum {IDLE, GRANT, DONE};
  - `FN_W`=8;
  - the bit-index constants `FN_D00`=7 … `FN_B0`=0.
- Sub-module `rr_pick`: combinational round-robin picker. It takes the request vector and pointer and returns a grant-valid flag plus the winner index.
- The top level owns the FSM and registers, and instantiates `rr_pick` once and `s2` once.

## Test plan
- Single request, cell selects d01:
  - Stimulus: after reset, `req`=4'b0001 with `fn[0]`=8'b0100_0011.
  - Expected: `rsp_valid`=1 with `rsp_data`=1, `rsp_id`=0 and `ack`=4'b0001 exactly 2 cycles later; `busy` low afterwards.
- Single request, cell selects d10:
  - Stimulus: `fn[3]`=8'b0010_1001 on requester 3.
  - Expected: `rsp_data`=1, `rsp_id`=3. The same request with `fn`=8'b1101_1001 gives `rsp_data`=0.
- All requesters at once:
  - Stimulus: all four `req` high after reset, each dropped on its own `ack`.
  - Expected: `rsp_id` sequence 0,1,2,3 with `rsp_valid` every 2 cycles; idle after the 4th response.
- Fairness under continuous load:
  - Stimulus: `req[0]` held permanently, `req[2]` re-raised after each ack.
  - Expected: served ids alternate 0,2,0,2; neither requester is ever served twice in a row while the other waits.
- Reset mid-operation:
  - Stimulus: pulse `clr_n` low during GRANT of requester 1, keeping `req[1]` high.
  - Expected: outputs are 0 immediately and no `ack` appears for the discarded operation. After release, requester 1 is served with a full 2-cycle latency and correct data.
- Cell output masking:
  - Stimulus: `fn`=8'hFF (expected response 1).
  - Expected: the cell output is 0 in every IDLE and GRANT cycle and 1 only in DONE.
